// File: rtl/i2c_write_sequencer_if.sv
// Bundles the requester, control/status and engine-side signals of the I2C write sequencer.
// slave: the sequencer's view. It takes push/go/engComplete and drives status plus the engine controls.
// master: the view of whatever surrounds the sequencer (requester and byte engine).
interface i2c_write_sequencer_if #(
  parameter int FIFO_DEPTH = 16
);
  localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

  // requester side
  logic               pushValid;
  logic [7:0]         pushData;
  logic               pushReady;
  // transaction control / status
  logic               go;
  logic               addrOverride;
  logic [6:0]         slaveAddr;
  logic               busy;
  logic               done;
  logic               timeoutErr;
  logic [LEVEL_W-1:0] fifoLevel;
  // byte engine side
  logic [1:0]         engInstruction;
  logic               engEnable;
  logic [7:0]         engByteToSend;
  logic               engComplete;

  modport slave (
    input  pushValid, pushData, go, addrOverride, slaveAddr, engComplete,
    output pushReady, busy, done, timeoutErr, fifoLevel,
           engInstruction, engEnable, engByteToSend
  );

  modport master (
    output pushValid, pushData, go, addrOverride, slaveAddr, engComplete,
    input  pushReady, busy, done, timeoutErr, fifoLevel,
           engInstruction, engEnable, engByteToSend
  );
endinterface

// File: rtl/i2c_write_sequencer.sv
// Drives a byte-level I2C engine through START, address+W, N buffered payload bytes and STOP.
// Latency: busy rises the cycle after an accepted go. Each engine step takes ISSUE/WAIT/RELEASE cycles.
// Backpressure: pushReady drops when the FIFO is full, except in a pop cycle. go is ignored unless idle.
// Ports: clk, resetN (async, active low), bus (i2c_write_sequencer_if.slave).
module i2c_write_sequencer #(
  parameter int         FIFO_DEPTH     = 16,
  parameter logic [6:0] DEFAULT_ADDR   = 7'h3C,
  parameter int         TIMEOUT_CYCLES = 4096
) (
  input  logic                        clk,
  input  logic                        resetN,
  i2c_write_sequencer_if.slave        bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] INSTR_START = 2'd0;
  localparam logic [1:0] INSTR_STOP  = 2'd1;
  localparam logic [1:0] INSTR_WRITE = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RELEASE, S_FLUSH, S_DONE} state_t;
  typedef enum logic [1:0] {P_START, P_ADDR, P_DATA, P_STOP} phase_t;

  state_t          state, state_nxt;
  phase_t          phase, phase_nxt;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   level;
  logic [LW-1:0]   count;       // payload bytes still owed to this transaction
  logic [7:0]      addr_byte;
  logic [TW-1:0]   step_cnt;
  logic [1:0]      instr_q;
  logic [7:0]      byte_q;
  logic            timeout_err_q;
  logic            full, push, pop, go_acc, step_timeout;
  logic            busy_c, done_c, enable_c;

  assign full         = (level == LW'(FIFO_DEPTH));
  // Pops happen when a DATA step completes and while an aborted transaction discards its bytes.
  assign pop          = (state == S_WAIT && phase == P_DATA && bus.engComplete) ||
                        (state == S_FLUSH && count != '0);
  // A same-cycle pop frees a slot, so a push is still taken when full.
  assign bus.pushReady = !full || pop;
  assign push         = bus.pushValid && bus.pushReady;
  assign go_acc       = (state == S_IDLE) && bus.go;
  assign step_timeout = (state == S_ISSUE || state == S_WAIT) &&
                        (step_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Phase that follows the current step. count has already been decremented by the time RELEASE is reached.
  always_comb begin
    phase_nxt = phase;
    unique case (phase)
      P_START:        phase_nxt = P_ADDR;
      P_ADDR, P_DATA: phase_nxt = (count != '0) ? P_DATA : P_STOP;
      P_STOP:         phase_nxt = P_STOP;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // FSM: next state. A step's own progress wins over a timeout landing in the same cycle.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (bus.go) state_nxt = S_ISSUE;
      S_ISSUE:   if (!bus.engComplete) state_nxt = S_WAIT;
                 else if (step_timeout) state_nxt = S_FLUSH;
      S_WAIT:    if (bus.engComplete) state_nxt = S_RELEASE;
                 else if (step_timeout) state_nxt = S_FLUSH;
      S_RELEASE: state_nxt = (phase == P_STOP) ? S_DONE : S_ISSUE;
      S_FLUSH:   if (count == '0) state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs. During the done cycle busy is already low, but the block only reaches IDLE on the next cycle.
  always_comb begin
    busy_c   = 1'b0;
    done_c   = 1'b0;
    enable_c = 1'b0;
    unique case (state)
      S_ISSUE, S_WAIT: begin busy_c = 1'b1; enable_c = 1'b1; end
      S_RELEASE, S_FLUSH: busy_c = 1'b1;
      S_DONE:             done_c = 1'b1;
      default: ;
    endcase
  end

  assign bus.busy           = busy_c;
  assign bus.done           = done_c;
  assign bus.engEnable      = enable_c;
  assign bus.engInstruction = instr_q;
  assign bus.engByteToSend  = byte_q;
  assign bus.timeoutErr     = timeout_err_q;
  assign bus.fifoLevel      = level;

  // Payload storage. Contents are meaningless after reset because the pointers restart.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.pushData;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      count         <= '0;
      addr_byte     <= '0;
      step_cnt      <= '0;
      instr_q       <= INSTR_START;
      byte_q        <= '0;
      timeout_err_q <= 1'b0;
      phase         <= P_START;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: ;
      endcase

      if (go_acc) begin
        // Only bytes already queued belong to this transaction.
        count         <= level;
        addr_byte     <= {(bus.addrOverride ? bus.slaveAddr : DEFAULT_ADDR), 1'b0};
        timeout_err_q <= 1'b0;
        phase         <= P_START;
        instr_q       <= INSTR_START;
        byte_q        <= '0;
        step_cnt      <= '0;
      end else begin
        if (pop) count <= count - LW'(1);
        if (step_timeout && state_nxt == S_FLUSH) timeout_err_q <= 1'b1;
        if (state == S_RELEASE && state_nxt == S_ISSUE) begin
          // Engine inputs are captured on ISSUE entry so they stay put while the head pointer moves.
          phase    <= phase_nxt;
          step_cnt <= '0;
          unique case (phase_nxt)
            P_ADDR:  begin instr_q <= INSTR_WRITE; byte_q <= addr_byte;   end
            P_DATA:  begin instr_q <= INSTR_WRITE; byte_q <= mem[rd_ptr]; end
            P_STOP:  begin instr_q <= INSTR_STOP;  byte_q <= '0;          end
            default: begin instr_q <= INSTR_START; byte_q <= '0;          end
          endcase
        end else if (state == S_ISSUE || state == S_WAIT) begin
          step_cnt <= step_cnt + TW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_i2c_write_sequencer.sv
module tb_i2c_write_sequencer;
  logic clk = 1'b0;
  logic resetN;
  always #5 clk = ~clk;

  i2c_write_sequencer_if #(.FIFO_DEPTH(16)) bus();

  i2c_write_sequencer #(
    .FIFO_DEPTH(16), .DEFAULT_ADDR(7'h3C), .TIMEOUT_CYCLES(4096)
  ) dut (
    .clk(clk), .resetN(resetN), .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Engine model: completes enabled instructions after reply_delay+1 cycles, logs {instr, byte},
  // and keeps complete high for hold_extra cycles after enable drops.
  int         reply_delay;
  int         hold_extra;
  bit         hang_write;
  int         eng_cnt;
  int         hold_cnt;
  bit         seen_low;
  logic [9:0] log_q[$];
  logic [9:0] exp_q[$];

  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      bus.engComplete <= 1'b0;
      eng_cnt  <= 0;
      hold_cnt <= 0;
      seen_low <= 1'b0;
    end else if (!bus.engComplete) begin
      if (bus.engEnable && !(hang_write && bus.engInstruction == 2'd3)) begin
        if (eng_cnt >= reply_delay) begin
          bus.engComplete <= 1'b1;
          eng_cnt <= 0;
          log_q.push_back({bus.engInstruction,
                           (bus.engInstruction == 2'd3) ? bus.engByteToSend : 8'h00});
        end else begin
          eng_cnt <= eng_cnt + 1;
        end
      end else begin
        eng_cnt <= 0;
      end
    end else if (seen_low || !bus.engEnable) begin
      seen_low <= 1'b1;
      if (hold_cnt >= hold_extra) begin
        bus.engComplete <= 1'b0;
        hold_cnt <= 0;
        seen_low <= 1'b0;
      end else begin
        hold_cnt <= hold_cnt + 1;
      end
    end
  end

  int done_cnt = 0;
  int stop_cnt = 0;
  always @(negedge clk) begin
    if (bus.done) done_cnt++;
    if (bus.engEnable && bus.engInstruction == 2'd1) stop_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic push_byte(input logic [7:0] b, output bit acc);
    @(negedge clk);
    bus.pushValid = 1'b1;
    bus.pushData  = b;
    #1;
    acc = bus.pushReady;
    @(negedge clk);
    bus.pushValid = 1'b0;
  endtask

  task automatic start_go(input bit ovr, input logic [6:0] addr);
    @(negedge clk);
    bus.go = 1'b1;
    bus.addrOverride = ovr;
    bus.slaveAddr = addr;
    @(negedge clk);
    bus.go = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, output int cycles);
    bit seen;
    seen = 1'b0;
    cycles = 0;
    while (!seen && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (bus.done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, seen, 1);
  endtask

  task automatic check_log(input string tag, input int base);
    check({tag, "_steps"}, log_q.size() - base, exp_q.size());
    foreach (exp_q[i])
      if (base + i < log_q.size())
        check($sformatf("%s_step%0d", tag, i), log_q[base + i], exp_q[i]);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},      bus.busy, 0);
    check({tag, "_done"},      bus.done, 0);
    check({tag, "_terr"},      bus.timeoutErr, 0);
    check({tag, "_en"},        bus.engEnable, 0);
    check({tag, "_instr"},     bus.engInstruction, 0);
    check({tag, "_byte"},      bus.engByteToSend, 0);
    check({tag, "_pushready"}, bus.pushReady, 1);
    check({tag, "_level"},     bus.fifoLevel, 0);
  endtask

  initial begin
    int  base, d0, s0, cyc, nacc, n, at_log;
    bit  acc;

    reply_delay = 127;
    hold_extra  = 0;
    hang_write  = 1'b0;
    resetN = 1'b0;
    bus.pushValid = 1'b0;
    bus.pushData = 8'h00;
    bus.go = 1'b0;
    bus.addrOverride = 1'b0;
    bus.slaveAddr = 7'h00;

    // Reset state
    #12;
    check_idle_outputs("reset");
    @(negedge clk);
    resetN = 1'b1;

    // Default address, three payload bytes, slow engine
    push_byte(8'h00, acc);
    push_byte(8'hAE, acc);
    push_byte(8'hAF, acc);
    check("t1_level_loaded", bus.fifoLevel, 3);
    base = log_q.size();
    d0 = done_cnt;
    start_go(1'b0, 7'h00);
    #1;
    check("t1_busy_after_go", bus.busy, 1);
    wait_done("t1", 2000, cyc);
    check("t1_busy_at_done", bus.busy, 0);
    repeat (4) @(negedge clk);
    exp_q = {10'h000, 10'h378, 10'h300, 10'h3AE, 10'h3AF, 10'h100};
    check_log("t1", base);
    check("t1_done_pulses", done_cnt - d0, 1);
    check("t1_level_end", bus.fifoLevel, 0);
    check("t1_terr", bus.timeoutErr, 0);

    // Address probe with override
    reply_delay = 2;
    base = log_q.size();
    d0 = done_cnt;
    start_go(1'b1, 7'h50);
    wait_done("t2", 200, cyc);
    repeat (4) @(negedge clk);
    exp_q = {10'h000, 10'h3A0, 10'h100};
    check_log("t2", base);
    check("t2_done_pulses", done_cnt - d0, 1);

    // Full FIFO, rejected 17th push, push accepted alongside the first data pop
    nacc = 0;
    for (int i = 0; i < 16; i++) begin
      push_byte(8'h10 + 8'(i), acc);
      nacc += int'(acc);
    end
    check("t3_accepted16", nacc, 16);
    #1;
    check("t3_pushready_full", bus.pushReady, 0);
    push_byte(8'hEE, acc);
    check("t3_push17_rejected", acc, 0);
    check("t3_level_full", bus.fifoLevel, 16);
    base = log_q.size();
    d0 = done_cnt;
    start_go(1'b0, 7'h00);
    bus.pushValid = 1'b1;
    bus.pushData = 8'h99;
    acc = 1'b0;
    n = 0;
    at_log = 0;
    while (!acc && n < 2000) begin
      #1;
      if (bus.pushReady) begin
        acc = 1'b1;
        at_log = log_q.size() - base;
      end
      @(negedge clk);
      n++;
    end
    bus.pushValid = 1'b0;
    check("t3_late_push_taken", acc, 1);
    check("t3_late_push_at_first_pop", at_log, 3);
    check("t3_level_after_late_push", bus.fifoLevel, 16);
    wait_done("t3", 1000, cyc);
    repeat (4) @(negedge clk);
    exp_q = {10'h000, 10'h378};
    for (int i = 0; i < 16; i++) exp_q.push_back({2'd3, 8'h10 + 8'(i)});
    exp_q.push_back(10'h100);
    check_log("t3", base);
    check("t3_level_left", bus.fifoLevel, 1);
    check("t3_done_pulses", done_cnt - d0, 1);

    // Stale complete held into the next ISSUE; the leftover 0x99 is the payload
    reply_delay = 3;
    hold_extra  = 4;
    base = log_q.size();
    start_go(1'b0, 7'h00);
    wait_done("t4", 500, cyc);
    repeat (8) @(negedge clk);
    exp_q = {10'h000, 10'h378, 10'h399, 10'h100};
    check_log("t4", base);
    check("t4_level_end", bus.fifoLevel, 0);
    hold_extra = 0;

    // Engine never completes the address step: abort and flush
    reply_delay = 2;
    hang_write  = 1'b1;
    push_byte(8'h01, acc);
    push_byte(8'h02, acc);
    push_byte(8'h03, acc);
    base = log_q.size();
    d0 = done_cnt;
    s0 = stop_cnt;
    start_go(1'b0, 7'h00);
    wait_done("t5", 6000, cyc);
    check("t5_abort_time", (cyc >= 4096 && cyc <= 4140), 1);
    check("t5_en_at_done", bus.engEnable, 0);
    check("t5_terr_set", bus.timeoutErr, 1);
    check("t5_level_flushed", bus.fifoLevel, 0);
    repeat (4) @(negedge clk);
    exp_q = {10'h000};
    check_log("t5", base);
    check("t5_no_stop", stop_cnt - s0, 0);
    check("t5_done_pulses", done_cnt - d0, 1);
    check("t5_terr_sticky", bus.timeoutErr, 1);
    hang_write = 1'b0;
    base = log_q.size();
    start_go(1'b0, 7'h00);
    #1;
    check("t5_terr_cleared_by_go", bus.timeoutErr, 0);
    wait_done("t5b", 200, cyc);
    repeat (4) @(negedge clk);
    exp_q = {10'h000, 10'h378, 10'h100};
    check_log("t5b", base);

    // Asynchronous reset in the middle of the data phase
    reply_delay = 5;
    push_byte(8'hA1, acc);
    push_byte(8'hA2, acc);
    push_byte(8'hA3, acc);
    base = log_q.size();
    start_go(1'b0, 7'h00);
    n = 0;
    while ((log_q.size() - base) < 3 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("t6_reached_data", (log_q.size() - base) >= 3, 1);
    #2;
    resetN = 1'b0;
    #1;
    check_idle_outputs("t6_async");
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    push_byte(8'h5A, acc);
    base = log_q.size();
    start_go(1'b1, 7'h21);
    wait_done("t6", 500, cyc);
    repeat (4) @(negedge clk);
    exp_q = {10'h000, 10'h342, 10'h35A, 10'h100};
    check_log("t6", base);
    check("t6_level_end", bus.fifoLevel, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
